// File: rtl/bist_pattern_engine_pkg.sv
// bist_pattern_engine_pkg: FSM state encoding and default constants shared by the BIST datapath.
package bist_pattern_engine_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;
    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_MISR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED      = 8'h01;
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: left-shifting Fibonacci LFSR with parallel load; din != 0 turns it into a MISR.
module bist_lfsr
    import bist_pattern_engine_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   TAPS = W'(DEF_LFSR_TAPS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = load ? load_val : en ? ({q_q[W-2:0], ^(q_q & TAPS)} ^ din) : q_q;
    always_ff @(posedge clk) q_q <= reset ? '0 : q_d;
    assign q = q_q;
endmodule

// File: rtl/bist_pattern_engine.sv
// bist_pattern_engine: drives LFSR patterns into the CUT, compacts responses in a MISR,
// and reports end-of-test plus golden-signature match to the BIST controller.
module bist_pattern_engine
    import bist_pattern_engine_pkg::*;
#(
    parameter int                PAT_W        = 8,
    parameter int                RESP_W       = 8,
    parameter logic [PAT_W-1:0]  LFSR_TAPS    = PAT_W'(DEF_LFSR_TAPS),
    parameter logic [RESP_W-1:0] MISR_TAPS    = RESP_W'(DEF_MISR_TAPS),
    parameter logic [PAT_W-1:0]  SEED         = PAT_W'(DEF_SEED),
    parameter int                NUM_PATTERNS = 255,
    parameter int                CNT_W        = 8,
    parameter logic [RESP_W-1:0] GOLDEN       = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [RESP_W-1:0] cut_resp,
    output logic [PAT_W-1:0]  pattern,
    output logic [RESP_W-1:0] signature,
    output logic              bist_end,
    output logic              sig_ok,
    output logic              busy
);
    // An all-zero seed would lock the TPG at zero.
    localparam logic [PAT_W-1:0] SEED_EFF = (SEED == '0) ? PAT_W'(1) : SEED;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load, last, in_run;

    always_comb begin
        load    = state_q == LOAD;
        in_run  = state_q == RUN;
        last    = count_q == LAST;
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = run ? LOAD : IDLE;
            LOAD:    state_d = run ? RUN : IDLE;
            RUN:     state_d = !run ? IDLE : last ? DONE : RUN;
            DONE:    state_d = run ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        count_d = load ? '0 : (in_run && !last) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The TPG holds on the final cycle so the last applied pattern stays visible in DONE.
    bist_lfsr #(.W(PAT_W), .TAPS(LFSR_TAPS)) u_tpg (
        .clk(clk), .reset(reset), .load(load), .load_val(SEED_EFF),
        .en(in_run && !last), .din('0), .q(pattern)
    );

    bist_lfsr #(.W(RESP_W), .TAPS(MISR_TAPS)) u_misr (
        .clk(clk), .reset(reset), .load(load), .load_val('0),
        .en(in_run), .din(cut_resp), .q(signature)
    );

    assign bist_end = state_q == DONE;
    assign sig_ok   = bist_end && (signature == GOLDEN);
    assign busy     = load || in_run;
endmodule
